// File: rtl/multi_digit_rate_counter_pkg.sv
// Shared constants for multi_digit_rate_counter: active-low seven-segment
// patterns (bit 0 = segment a .. bit 6 = segment g) and the rate-select encoding.
package multi_digit_rate_counter_pkg;

   typedef enum logic [1:0] {
      SEL_EVERY    = 2'b00,
      SEL_RELOAD_1 = 2'b01,
      SEL_RELOAD_2 = 2'b10,
      SEL_RELOAD_3 = 2'b11
   } select_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Element [n] is the pattern for value n (F is listed first, 0 last).
   localparam logic [15:0][6:0] SEG_DIGIT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/multi_digit_rate_counter_seg7_decoder.sv
// One-digit 4-bit to active-low seven-segment decoder (0-F), purely combinational.
module seg7_decoder
   import multi_digit_rate_counter_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DIGIT[value];
   end

endmodule

// File: rtl/multi_digit_rate_counter.sv
// Multi-digit up/down hex or BCD counter stepped by a selectable rate divider.
// Define MULTI_DIGIT_RATE_COUNTER_BLANK_EN to blank leading zero digits above digit 0.
module multi_digit_rate_counter
   import multi_digit_rate_counter_pkg::*;
#(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned BCD       = 0,
   parameter int unsigned DIV_WIDTH = 26,
   parameter int unsigned RELOAD_1  = 24999999,
   parameter int unsigned RELOAD_2  = 49999999,
   parameter int unsigned RELOAD_3  = 99999999
) (
   input  logic                  Clock,
   input  logic                  Clear_b,
   input  logic [1:0]            Select,
   input  logic                  Run,
   input  logic                  Up,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   Load_value,
   output logic [4*DIGITS-1:0]   Count,
   output logic [7*DIGITS-1:0]   HEX,
   output logic                  Tick,
   output logic                  Wrap
);

   localparam logic [3:0] DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'd15;

   logic [DIV_WIDTH-1:0] q;
   logic [DIV_WIDTH-1:0] reload_val;
   select_e              sel_prev;
   logic [4*DIGITS-1:0]  stepped;
   logic [4*DIGITS-1:0]  load_clean;
   logic                 step_wrap;
   logic                 carry;
   logic [3:0]           digit;

   always_comb begin
      case (select_e'(Select))
         SEL_EVERY:    reload_val = '0;
         SEL_RELOAD_1: reload_val = DIV_WIDTH'(RELOAD_1);
         SEL_RELOAD_2: reload_val = DIV_WIDTH'(RELOAD_2);
         SEL_RELOAD_3: reload_val = DIV_WIDTH'(RELOAD_3);
         default:      reload_val = '0;
      endcase
   end

   // A Select change restarts the period from the new reload without a Tick.
   always_ff @(posedge Clock or negedge Clear_b) begin
      if (!Clear_b) begin
         q        <= reload_val;
         sel_prev <= select_e'(Select);
         Tick     <= 1'b0;
      end else if (select_e'(Select) != sel_prev) begin
         q        <= reload_val;
         sel_prev <= select_e'(Select);
         Tick     <= 1'b0;
      end else if (q == '0) begin
         q    <= reload_val;
         Tick <= 1'b1;
      end else begin
         q    <= q - DIV_WIDTH'(1);
         Tick <= 1'b0;
      end
   end

   always_comb begin
      load_clean = Load_value;
      if (BCD != 0) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            if (Load_value[4*k +: 4] > 4'd9) begin
               load_clean[4*k +: 4] = 4'd0;
            end
         end
      end
   end

   // Ripple carry/borrow across all digits within one cycle.
   always_comb begin
      stepped = Count;
      carry   = 1'b1;
      digit   = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         digit = Count[4*k +: 4];
         if (carry) begin
            if (Up) begin
               if (digit >= DIGIT_MAX) begin
                  stepped[4*k +: 4] = '0;
               end else begin
                  stepped[4*k +: 4] = digit + 4'd1;
                  carry             = 1'b0;
               end
            end else begin
               if (digit == '0) begin
                  stepped[4*k +: 4] = DIGIT_MAX;
               end else begin
                  stepped[4*k +: 4] = digit - 4'd1;
                  carry             = 1'b0;
               end
            end
         end
      end
      step_wrap = carry;
   end

   always_ff @(posedge Clock or negedge Clear_b) begin
      if (!Clear_b) begin
         Count <= '0;
         Wrap  <= 1'b0;
      end else if (Load) begin
         Count <= load_clean;
         Wrap  <= 1'b0;
      end else if (Tick && Run) begin
         Count <= stepped;
         Wrap  <= step_wrap;
      end else begin
         Wrap  <= 1'b0;
      end
   end

`ifdef MULTI_DIGIT_RATE_COUNTER_BLANK_EN
   logic [DIGITS-1:0] blank;
   logic              all_zero;
   int unsigned       idx;

   always_comb begin
      blank    = '0;
      all_zero = 1'b1;
      idx      = 0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         idx        = DIGITS - 1 - i;
         all_zero   = all_zero && (Count[4*idx +: 4] == 4'd0);
         blank[idx] = all_zero && (idx != 0);
      end
   end
`endif

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [6:0] seg;

      seg7_decoder u_seg (
         .value (Count[4*k +: 4]),
         .seg   (seg)
      );

`ifdef MULTI_DIGIT_RATE_COUNTER_BLANK_EN
      assign HEX[7*k +: 7] = blank[k] ? SEG_BLANK : seg;
`else
      assign HEX[7*k +: 7] = seg;
`endif
   end

endmodule

// File: doc/multi_digit_rate_counter.md
MULTI_DIGIT_RATE_COUNTER -- requirements
Module: multi_digit_rate_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of 4-bit counter digits and seven-segment outputs (1..8).
REQ-002 Parameter BCD, default 0, digit modulus: 0 = hex (0..F), 1 = decimal (0..9).
REQ-003 Parameter DIV_WIDTH, default 26, width of the rate-divider down-counter.
REQ-004 Parameters RELOAD_1, RELOAD_2 and RELOAD_3, defaults 24999999, 49999999 and 99999999, are the divider reload values for Select 01, 10 and 11.
REQ-005 Clock  in  1  system clock (50 MHz); all state changes on rising edge.
REQ-006 Clear_b  in  1  asynchronous, active-low reset.
REQ-007 Select  in  2  rate select; 00 = tick every Clock, 01/10/11 = tick every RELOADn+1 Clocks.
REQ-008 Run  in  1  1 = count on tick, 0 = hold count (divider keeps running).
REQ-009 Up  in  1  1 = increment, 0 = decrement.
REQ-010 Load  in  1  synchronous load of Load_value, highest priority after reset.
REQ-011 Load_value  in  4*DIGITS  digit values, digit 0 in bits [3:0].
REQ-012 Count  out  4*DIGITS  current digit values.
REQ-013 HEX  out  7*DIGITS  active-low segments, digit k in bits [7k+6:7k], bit 0 = segment a … bit 6 = segment g.
REQ-014 Tick  out  1  one-cycle pulse when the divider expires.
REQ-015 Wrap  out  1  one-cycle pulse on the cycle the whole count wraps (max->0 up, 0->max down).

Function
REQ-016 Divider: DIV_WIDTH-bit down-counter q; on q==0 it SHALL assert Tick for one cycle and reload the selected value, otherwise decrement; Select 00 SHALL hold q at 0 so that Tick is high every cycle.
REQ-017 A change of Select (registered compare against its previous value) SHALL reload q with the new value on the next edge without asserting Tick; reload values wider than DIV_WIDTH are truncated.
REQ-018 Count priority per edge: Load > (Tick & Run) step > hold; Load SHALL NOT pulse Wrap.
REQ-019 With BCD=1, any loaded digit above 9 SHALL be replaced by 0.
REQ-020 Step up: digit 0 increments; a digit at its max (F or 9) SHALL go to 0 and carry into the next digit in the same cycle.
REQ-021 Step down: a digit at 0 SHALL go to its max and borrow from the next digit in the same cycle.
REQ-022 Wrap SHALL be asserted in the same cycle the carry/borrow leaves the top digit; Count SHALL equal all-0 (up) or all-max (down) on that cycle.
REQ-023 Up sampled on the stepping edge; a direction change takes effect on the next tick.
REQ-024 HEX SHALL be a pure combinational decode of Count (no added latency); BCD=1 still decodes A-F if reachable.

Reset
REQ-025 Clear_b low SHALL immediately force q=RELOAD of the current Select (0 for Select 00), Count=0, Tick=0, Wrap=0, and the stored Select=current Select.
REQ-026 On Clear_b release, the first Tick SHALL occur after a full divider period; reset mid-count discards the count.

Configuration
REQ-027 Macro MULTI_DIGIT_RATE_COUNTER_BLANK_EN: when defined, leading zero digits above digit 0 SHALL drive HEX all-ones (blank); digit 0 is never blanked.
REQ-028 Without the macro, every digit always shows its value; Count behaviour is identical in both builds.

Structure
REQ-029 Shared package holds the 7-bit segment constants for 0-F, the SEG_BLANK constant (7'h7F) and the Select encoding constants.
REQ-030 One sub-module seg7_decoder (4-bit in, 7-bit active-low out), instantiated DIGITS times via generate; divider and count chain stay in the top module.

Verification (DIGITS=2, RELOAD_1=3, RELOAD_2=7, RELOAD_3=15 unless stated)
REQ-031 Select=01, Run=1, Up=1 from reset -> Tick every 4 Clocks; Count 0x00,0x01,0x02… one step per Tick.
REQ-032 Load 0xFE, Up=1, Select=00 -> Count 0xFF then 0x00 with Wrap=1 for exactly that cycle; HEX digit1 = 7'h0E at 0xFE.
REQ-033 BCD=1, Load 0x00, Up=0, Select=00 -> Count 0x99 with Wrap=1, then 0x98; Load 0x3C -> Count 0x30.
REQ-034 Select 01->11 mid-period -> no Tick for 16 Clocks after the change, then a Tick every 16 Clocks.
REQ-035 Clear_b low for 1 cycle mid-count at 0x47 -> Count=0x00, Tick=0 asynchronously; Run=0 holds Count while Tick keeps pulsing.
REQ-036 BLANK_EN build, Count 0x05 -> HEX digit1 = 7'h7F, digit0 = 7'h12; without macro digit1 = 7'h40.
